// File: rtl/mmio_peripheral.sv
// Memory-mapped peripheral block: reloadable timer with sticky IRQ, LED/7-seg
// output registers, synchronised switches and a free-running systick counter.
module mmio_peripheral #(
  parameter logic [31:0] BASE = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic [7:0]  switch,
  output logic [7:0]  leds,
  output logic [11:0] digi,
  output logic        irqout
);

  // Bus semantics: no handshake. MemRead/MemWrite are single-cycle strobes that
  // are always accepted; loads return combinationally in the same cycle, stores
  // commit on the next posedge, and a load concurrent with a store sees old data.
  localparam logic [31:0] ADDR_TH      = BASE + 32'h00;
  localparam logic [31:0] ADDR_TL      = BASE + 32'h04;
  localparam logic [31:0] ADDR_TCON    = BASE + 32'h08;
  localparam logic [31:0] ADDR_LED     = BASE + 32'h0C;
  localparam logic [31:0] ADDR_SWITCH  = BASE + 32'h10;
  localparam logic [31:0] ADDR_DIGI    = BASE + 32'h14;
  localparam logic [31:0] ADDR_SYSTICK = BASE + 32'h18;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;

  logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
  logic tl_wrap;
  logic overflow;

  assign wr_th   = MemWrite && (Address == ADDR_TH);
  assign wr_tl   = MemWrite && (Address == ADDR_TL);
  assign wr_tcon = MemWrite && (Address == ADDR_TCON);
  assign wr_led  = MemWrite && (Address == ADDR_LED);
  assign wr_digi = MemWrite && (Address == ADDR_DIGI);

  assign tl_wrap  = tcon[0] && (tl == 32'hFFFFFFFF);
  assign overflow = tl_wrap && tcon[1];
  assign irqout   = tcon[2];

  always_comb begin
    Read_data = 32'h0;
    if (MemRead) begin
      case (Address)
        ADDR_TH:      Read_data = th;
        ADDR_TL:      Read_data = tl;
        ADDR_TCON:    Read_data = {29'h0, tcon};
        ADDR_LED:     Read_data = {24'h0, leds};
        ADDR_SWITCH:  Read_data = {24'h0, sw_sync};
        ADDR_DIGI:    Read_data = {20'h0, digi};
        ADDR_SYSTICK: Read_data = systick;
        default:      Read_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= 32'h0;
      tl   <= 32'h0;
      tcon <= 3'b000;
    end else begin
      if (wr_th) th <= Write_data;

      // CPU store to TL beats the timer's own increment/reload.
      if (wr_tl)        tl <= Write_data;
      else if (tl_wrap) tl <= th;
      else if (tcon[0]) tl <= tl + 32'd1;

      // An overflow in the same cycle as a TCON store still sets the flag.
      if (wr_tcon)       tcon <= {Write_data[2] | overflow, Write_data[1:0]};
      else if (overflow) tcon[2] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds    <= 8'h0;
      digi    <= 12'h0;
      systick <= 32'h0;
      sw_meta <= 8'h0;
      sw_sync <= 8'h0;
    end else begin
      if (wr_led)  leds <= Write_data[7:0];
      if (wr_digi) digi <= Write_data[11:0];
      systick <= systick + 32'd1;
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

endmodule

// File: tb/tb_mmio_peripheral.sv
// Directed bench for mmio_peripheral: a vector table for register access and
// decode, plus hand-written sequences for reset, timer, IRQ and switch sync.
module tb_mmio_peripheral;

  localparam logic [31:0] A_TH      = 32'h40000000;
  localparam logic [31:0] A_TL      = 32'h40000004;
  localparam logic [31:0] A_TCON    = 32'h40000008;
  localparam logic [31:0] A_LED     = 32'h4000000C;
  localparam logic [31:0] A_SWITCH  = 32'h40000010;
  localparam logic [31:0] A_DIGI    = 32'h40000014;
  localparam logic [31:0] A_SYSTICK = 32'h40000018;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic [7:0]  switch;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        irqout;

  mmio_peripheral #(.BASE(32'h40000000)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .switch     (switch),
    .leds       (leds),
    .digi       (digi),
    .irqout     (irqout)
  );

  // clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic score(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %h want <empty queue>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // drivers: all drive happens in the low phase, commits on the next posedge
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    MemWrite   = 1'b1;
    Address    = addr;
    Write_data = data;
    cycle();
    MemWrite   = 1'b0;
    Write_data = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    MemRead = 1'b1;
    Address = addr;
    #1;
    data    = Read_data;
    MemRead = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[22];
  logic [31:0] rv;
  logic [31:0] tick0;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, A_LED,        32'h000001A5, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b1, A_DIGI,       32'h00000F3C, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b1, A_LED,        32'h0,        32'h000000A5};
    vecs[3]  = '{1'b0, 1'b1, A_DIGI,       32'h0,        32'h00000F3C};
    vecs[4]  = '{1'b1, 1'b0, A_TH,         32'h12345678, 32'h00000000};
    vecs[5]  = '{1'b0, 1'b1, A_TH,         32'h0,        32'h12345678};
    vecs[6]  = '{1'b1, 1'b0, A_TL,         32'hCAFEF00D, 32'h00000000};
    vecs[7]  = '{1'b0, 1'b1, A_TL,         32'h0,        32'hCAFEF00D};
    vecs[8]  = '{1'b1, 1'b0, A_TCON,       32'hFFFFFFFA, 32'h00000000};
    vecs[9]  = '{1'b0, 1'b1, A_TCON,       32'h0,        32'h00000002};
    vecs[10] = '{1'b1, 1'b0, A_TCON,       32'h00000000, 32'h00000000};
    vecs[11] = '{1'b0, 1'b1, 32'h40000002, 32'h0,        32'h00000000};
    vecs[12] = '{1'b0, 1'b1, 32'h4000001C, 32'h0,        32'h00000000};
    vecs[13] = '{1'b1, 1'b0, 32'h40000001, 32'h000000FF, 32'h00000000};
    vecs[14] = '{1'b0, 1'b1, A_LED,        32'h0,        32'h000000A5};
    vecs[15] = '{1'b0, 1'b0, A_LED,        32'h0,        32'h00000000};
    vecs[16] = '{1'b1, 1'b0, A_SWITCH,     32'h000000FF, 32'h00000000};
    vecs[17] = '{1'b0, 1'b1, A_SWITCH,     32'h0,        32'h00000000};
    vecs[18] = '{1'b1, 1'b0, 32'h5000000C, 32'h0000003C, 32'h00000000};
    vecs[19] = '{1'b0, 1'b1, A_LED,        32'h0,        32'h000000A5};
    vecs[20] = '{1'b0, 1'b1, A_TL,         32'h0,        32'hCAFEF00D};
    vecs[21] = '{1'b0, 1'b1, A_TCON,       32'h0,        32'h00000000};

    reset      = 1'b1;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = 32'h0;
    Write_data = 32'h0;
    switch     = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset while operating: preload, then assert reset mid-cycle
    bus_write(A_TL, 32'h00000055);
    bus_write(A_LED, 32'h00000077);
    #2 reset = 1'b1;
    #1;
    check("rst_leds", {24'h0, leds}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      bus_read(A_TH + 32'(i * 4), rv);
      check($sformatf("rst_read_%0d", i), rv, 32'h0);
    end
    check("rst_digi", {20'h0, digi}, 32'h0);
    check("rst_irq", {31'h0, irqout}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_SYSTICK, rv);
    check("systick_0", rv, 32'h0);
    cycle();
    bus_read(A_SYSTICK, rv);
    check("systick_1", rv, 32'h1);
    cycle();
    bus_read(A_SYSTICK, rv);
    check("systick_2", rv, 32'h2);

    // table-driven register access and decode
    for (int i = 0; i < 22; i++) begin
      MemWrite   = vecs[i].wr;
      MemRead    = vecs[i].rd;
      Address    = vecs[i].addr;
      Write_data = vecs[i].wdata;
      #1;
      exp_q.push_back(vecs[i].exp);
      score($sformatf("vec%0d", i), Read_data);
      cycle();
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
    check("leds_out", {24'h0, leds}, 32'h000000A5);
    check("digi_out", {20'h0, digi}, 32'h00000F3C);

    // store to SYSTICK is ignored; counter keeps counting
    bus_read(A_SYSTICK, tick0);
    bus_write(A_SYSTICK, 32'h0);
    bus_read(A_SYSTICK, rv);
    check("systick_wr_ignored", rv, tick0 + 32'd1);

    // timer: TH=TL=FFFFFFFC, enable with IRQ; overflow 4 edges later
    bus_write(A_TH, 32'hFFFFFFFC);
    bus_write(A_TL, 32'hFFFFFFFC);
    bus_write(A_TCON, 32'h3);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("irq_pre_%0d", k), {31'h0, irqout}, 32'h0);
      cycle();
    end
    check("irq_rise", {31'h0, irqout}, 32'h1);
    bus_read(A_TL, rv);
    check("tl_reload", rv, 32'hFFFFFFFC);

    // acknowledge; next overflow 4 edges after the previous one
    bus_write(A_TCON, 32'h3);
    check("irq_ack", {31'h0, irqout}, 32'h0);
    cycle();
    check("irq_wait_1", {31'h0, irqout}, 32'h0);
    cycle();
    check("irq_wait_2", {31'h0, irqout}, 32'h0);
    cycle();
    check("irq_rerise", {31'h0, irqout}, 32'h1);

    // set beats clear: store TCON=3 on the cycle TL is all-ones
    repeat (3) cycle();
    bus_read(A_TL, rv);
    check("tl_ffff", rv, 32'hFFFFFFFF);
    bus_write(A_TCON, 32'h3);
    bus_read(A_TCON, rv);
    check("tcon_set_wins", rv, 32'h7);
    check("irq_held", {31'h0, irqout}, 32'h1);

    // switch synchroniser: two edges of latency
    switch = 8'h5A;
    bus_read(A_SWITCH, rv);
    check("sw_edge0", rv, 32'h0);
    cycle();
    bus_read(A_SWITCH, rv);
    check("sw_edge1", rv, 32'h0);
    cycle();
    bus_read(A_SWITCH, rv);
    check("sw_edge2", rv, 32'h0000005A);

    // asynchronous reset drops irqout immediately
    check("irq_before_rst", {31'h0, irqout}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_irq_async", {31'h0, irqout}, 32'h0);
    check("rst_leds_async", {24'h0, leds}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_TCON, rv);
    check("rst_tcon", rv, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_peripheral.md
# mmio_peripheral

Memory-mapped peripheral responder on the CPU data-memory bus, answering loads and stores in the `0x4000_0000` window alongside the data RAM. It contains:
- a reloadable 32-bit timer with a sticky interrupt flag,
- an LED output register, a synchronised switch input and a 7-segment digit register,
- a free-running cycle counter (systick).

Reads are combinational, so a load completes in the same single cycle as the instruction. Writes commit on the clock edge.

## Interface
- `BASE`, `32'h40000000`, base byte address of the register window.
- `clk` input 1: system clock, the same edge as the PC and register file.
- `reset` input 1: asynchronous, active-high.
- `MemRead` input 1: load strobe for the current cycle.
- `MemWrite` input 1: store strobe for the current cycle.
- `Address` input 32: byte address from the ALU.
- `Write_data` input 32: store data (rt value).
- `Read_data` output 32: load data, combinational.
- `switch` input 8: asynchronous board switches.
- `leds` output 8: LED register.
- `digi` output 12: 7-segment register; [11:8] is the anode select, [7:0] the segments.
- `irqout` output 1: timer interrupt request, level, equal to `TCON[2]`.

## Operation
Register map (offsets from `BASE`):
- `0x00` TH: 32-bit, R/W.
- `0x04` TL: 32-bit, R/W.
- `0x08` TCON: bits [2:0], R/W.
  - [0] timer enable.
  - [1] interrupt enable.
  - [2] interrupt status, sticky.
- `0x0C` LED: bits [7:0], R/W.
- `0x10` SWITCH: read-only, returns `{24'b0, sw_sync}`.
- `0x14` DIGI: bits [11:0], R/W.
- `0x18` SYSTICK: 32-bit, read-only.

Address decode:
- Full 32-bit compare.
- Any non-word-aligned address or address outside the map is unmapped: reads return 0 and writes are ignored.
- Writes to SWITCH or SYSTICK are ignored.
- Unused upper bits of narrow registers read as 0.

Read path:
- `Read_data` = selected register when `MemRead`=1.
- `Read_data` = 0 when `MemRead`=0.

Write path:
- When `MemWrite`=1 and the address is mapped, the register loads the matching low bits of `Write_data` at `posedge clk`.

Timer, evaluated each `posedge clk` when `TCON[0]`=1:
- If TL == `32'hFFFFFFFF`: TL <= TH, and if `TCON[1]`=1 then `TCON[2]` <= 1 (overflow event).
- Otherwise TL <= TL + 1.
- When `TCON[0]`=0, TL holds its value.

Collisions with CPU writes:
- A CPU write to TL in the same cycle overrides the increment or reload.
- A CPU write to TCON sets bits [1:0] from `Write_data[1:0]`.
  - Bit [2] becomes `Write_data[2] | overflow_event`; set wins, so a pending interrupt is never lost.
- Software acknowledges the interrupt by writing TCON with bit [2]=0.

Other counters and inputs:
- SYSTICK increments by 1 every cycle and wraps from `32'hFFFFFFFF` to 0.
- `sw_sync` is a 2-flop synchroniser on `switch`.

## Timing
Reset values (asynchronous):
- TH, TL, TCON, LED, DIGI, SYSTICK and both synchroniser stages = 0.
- Hence `leds`=0, `digi`=0, `irqout`=0.

Latencies:
- Read latency 0: `Read_data` is valid within the same cycle as `MemRead`/`Address`.
- Write latency 1 edge: the value is visible to reads and outputs in the cycle after the store.
- Simultaneous `MemRead` and `MemWrite` to the same register: the read returns the pre-write value.
- A switch change appears on SWITCH reads after 2 `posedge clk`.

Timer period:
- With TH=N and TCON=3 written while TL=N, the first overflow occurs after `2^32 - N` enabled cycles.
- Subsequent overflows occur every `2^32 - N` cycles.
- `irqout` rises in the cycle following the overflow edge.

Reset mid-operation:
- All state clears immediately.
- `irqout` drops asynchronously.
- No write is committed on the edge that coincides with reset being asserted.

## Test plan
- **Reset and idle:** assert `reset` with TL preloaded.
  - Required: all reads return 0, `leds`=0, `digi`=0, `irqout`=0; SYSTICK reads 0 then increments by 1 per cycle after release.
- **LED/DIGI write-read:** store `0x000001A5` to `0x4000000C`, then `0x00000F3C` to `0x40000014`.
  - Required: `leds`=`0xA5`, `digi`=`0xF3C` next cycle; readback `0x000000A5` and `0x00000F3C`.
- **Timer interrupt:** TH=TL=`0xFFFFFFFC`, TCON=3.
  - Required: `irqout`=1 exactly 4 cycles after the TCON write edge, and TL reads `0xFFFFFFFC` on that cycle.
  - Required: writing TCON=3 clears `irqout`, and it reasserts 4 cycles later.
- **Set-beats-clear:** write TCON=3 in the same cycle that TL==`0xFFFFFFFF`.
  - Required: TCON reads 7 next cycle and `irqout` stays 1.
- **Decode edges:**
  - Read `0x40000002` → 0; read `0x4000001C` → 0.
  - Store to `0x40000018` → SYSTICK unaffected.
  - `MemRead`=0 with a valid address → `Read_data`=0.
- **Switch sync:** change `switch` to `0x5A`.
  - Required: SWITCH read returns the old value for 2 edges, then `0x0000005A`.
